// File: rtl/dccm_mc_pkg.sv
// rtl/dccm_mc_pkg.sv - shared types, widths and round-robin helper for the DCCM bank arbiter
package dccm_mc_pkg;

    localparam int CNT_W      = 16;
    localparam int MAX_CH     = 8;
    localparam int PTR_W      = 3;
    localparam int REQ_ADDR_W = 14;
    localparam int REQ_DATA_W = 39;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } dccm_req_t;

    // One-hot grant of the first requester at or after ptr, scanning n channels.
    function automatic logic [MAX_CH-1:0] rr_pick(
        input logic [MAX_CH-1:0] req,
        input logic [PTR_W-1:0]  ptr,
        input int                n
    );
        logic [MAX_CH-1:0] g;
        int                idx;
        g = '0;
        for (int off = 0; off < MAX_CH; off++) begin
            idx = (int'(ptr) + off) % n;
            if (off < n && g == '0 && req[PTR_W'(idx)]) begin
                g[PTR_W'(idx)] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/dccm_mc_bank_ram.sv
// rtl/dccm_mc_bank_ram.sv - one single-port DCCM bank with synchronous read
module dccm_mc_bank_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 39
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Single access per cycle: write updates the array, read registers the word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dccm_mc_bank_arb.sv
// rtl/dccm_mc_bank_arb.sv - multi-channel DCCM controller with per-bank round-robin arbitration
module dccm_mc_bank_arb
    import dccm_mc_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_BITS  = 2,
    parameter int ADDR_BITS  = 14,
    parameter int DATA_WIDTH = 39,
    parameter int CH_BITS    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_override,
    input  logic [NUM_CH-1:0]            ch_req_valid,
    input  logic [NUM_CH-1:0]            ch_req_we,
    input  logic [NUM_CH*ADDR_BITS-1:0]  ch_req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_req_wdata,
    output logic [NUM_CH-1:0]            ch_req_ready,
    output logic [NUM_CH-1:0]            ch_rsp_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] ch_rsp_data,
    output logic [CNT_W-1:0]             bank_conflict_cnt
);

    localparam int BB    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int IDX_W = ADDR_BITS - BANK_BITS;

    // Per-channel decoded request fields
    logic [BB-1:0]         ch_bank  [NUM_CH];
    logic [IDX_W-1:0]      ch_idx   [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_wdata [NUM_CH];

    // Arbitration state and results
    logic [NUM_BANKS-1:0][NUM_CH-1:0] cand;
    logic [NUM_BANKS-1:0][NUM_CH-1:0] grant;
    logic [MAX_CH-1:0]                req_pad  [NUM_BANKS];
    logic [MAX_CH-1:0]                gnt_pad  [NUM_BANKS];
    logic [PTR_W-1:0]                 win      [NUM_BANKS];
    logic [CH_BITS-1:0]               rr_ptr   [NUM_BANKS];
    logic [CH_BITS-1:0]               next_ptr [NUM_BANKS];

    // Bank-side signals
    logic [NUM_BANKS-1:0]  bank_clk_en;
    logic [NUM_BANKS-1:0]  bank_acc;
    logic [NUM_BANKS-1:0]  bank_we;
    logic [IDX_W-1:0]      bank_addr  [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    // Response tracking
    logic [NUM_CH-1:0]     rsp_pend;
    logic [BB-1:0]         rsp_bank [NUM_CH];
    logic [DATA_WIDTH-1:0] rsp_hold [NUM_CH];
    logic [DATA_WIDTH-1:0] rsp_mux  [NUM_CH];

    // Conflict accounting
    logic [3:0]       cand_cnt [NUM_BANKS];
    logic [7:0]       conflict_k;
    logic [CNT_W:0]   cnt_sum;

    genvar gc, gb;

    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_dec
            assign ch_wdata[gc] = ch_req_wdata[gc*DATA_WIDTH +: DATA_WIDTH];
            if (BANK_BITS == 0) begin : g_one_bank
                assign ch_bank[gc] = '0;
                assign ch_idx[gc]  = ch_req_addr[gc*ADDR_BITS +: ADDR_BITS];
            end else begin : g_multi_bank
                assign ch_bank[gc] = ch_req_addr[gc*ADDR_BITS +: BANK_BITS];
                assign ch_idx[gc]  = ch_req_addr[gc*ADDR_BITS+BANK_BITS +: IDX_W];
            end
        end
    endgenerate

    // Candidates per bank: valid channels whose bank field selects that bank.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cand[b][c] = ch_req_valid[c] && (ch_bank[c] == BB'(b));
            end
        end
    end

    // Round-robin pick per bank and the pointer value that follows the winner.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_pad[b] = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                req_pad[b][c] = cand[b][c];
            end
            gnt_pad[b] = rr_pick(req_pad[b], PTR_W'(rr_ptr[b]), NUM_CH);
            win[b] = '0;
            for (int i = 0; i < MAX_CH; i++) begin
                if (gnt_pad[b][i]) begin
                    win[b] = PTR_W'(i);
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                grant[b][c] = (|gnt_pad[b]) && (win[b] == PTR_W'(c));
            end
            if (int'(win[b]) == NUM_CH - 1) begin
                next_ptr[b] = '0;
            end else begin
                next_ptr[b] = CH_BITS'(int'(win[b]) + 1);
            end
        end
    end

    // A channel is ready when its bank granted it; nothing is accepted under reset.
    always_comb begin
        ch_req_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (grant[b][c]) begin
                    ch_req_ready[c] = 1'b1;
                end
            end
        end
        if (rst) begin
            ch_req_ready = '0;
        end
    end

    // Route the granted channel's request to each bank; bank clock runs only when wanted.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_clk_en[b] = (|cand[b]) | clk_override;
            bank_acc[b]    = bank_clk_en[b] & (|grant[b]) & ~rst;
            bank_we[b]     = 1'b0;
            bank_addr[b]   = '0;
            bank_wdata[b]  = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (grant[b][c]) begin
                    bank_we[b]    = ch_req_we[c];
                    bank_addr[b]  = ch_idx[c];
                    bank_wdata[b] = ch_wdata[c];
                end
            end
        end
    end

    generate
        for (gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
            dccm_mc_bank_ram #(
                .ADDR_W (IDX_W),
                .DATA_W (DATA_WIDTH)
            ) u_ram (
                .clk   (clk),
                .en    (bank_acc[gb]),
                .we    (bank_we[gb]),
                .addr  (bank_addr[gb]),
                .wdata (bank_wdata[gb]),
                .rdata (bank_rdata[gb])
            );
        end
    endgenerate

    // Advance each bank's pointer past its winner; reset returns all pointers to channel 0.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rst) begin
                rr_ptr[b] <= '0;
            end else if (|grant[b]) begin
                rr_ptr[b] <= next_ptr[b];
            end
        end
    end

    // Response output: bank data on the return cycle, otherwise the last delivered word.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_rsp_valid[c] = rsp_pend[c] & ~rst;
            rsp_mux[c]      = ch_rsp_valid[c] ? bank_rdata[rsp_bank[c]] : rsp_hold[c];
            ch_rsp_data[c*DATA_WIDTH +: DATA_WIDTH] = rsp_mux[c];
        end
    end

    // Remember which bank each accepted read went to, and hold returned data.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                rsp_pend[c] <= 1'b0;
                rsp_bank[c] <= '0;
                rsp_hold[c] <= '0;
            end else begin
                rsp_pend[c] <= ch_req_ready[c] & ~ch_req_we[c];
                if (ch_req_ready[c] && !ch_req_we[c]) begin
                    rsp_bank[c] <= ch_bank[c];
                end
                rsp_hold[c] <= rsp_mux[c];
            end
        end
    end

    // Losing candidates across all banks this cycle.
    always_comb begin
        conflict_k = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            cand_cnt[b] = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cand_cnt[b] = cand_cnt[b] + 4'(cand[b][c]);
            end
            if (cand_cnt[b] > 4'd1) begin
                conflict_k = conflict_k + 8'(cand_cnt[b] - 4'd1);
            end
        end
        cnt_sum = {1'b0, bank_conflict_cnt} + (CNT_W+1)'(conflict_k);
    end

    // Saturating conflict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_conflict_cnt <= '0;
        end else if (cnt_sum[CNT_W]) begin
            bank_conflict_cnt <= '1;
        end else begin
            bank_conflict_cnt <= cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_dccm_mc_bank_arb.sv
// tb/tb_dccm_mc_bank_arb.sv - scoreboard bench for dccm_mc_bank_arb
module tb_dccm_mc_bank_arb;
    import dccm_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_override = 1'b0;
    logic [1:0]  valid = '0;
    logic [1:0]  we = '0;
    logic [27:0] addr = '0;
    logic [77:0] wdata = '0;
    logic [1:0]  ready;
    logic [1:0]  rsp_valid;
    logic [77:0] rsp_data;
    logic [15:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [38:0] exp_q0[$];
    logic [38:0] exp_q1[$];
    logic [38:0] e0, e1;

    localparam dccm_req_t NO = '0;

    dccm_mc_bank_arb dut (
        .clk               (clk),
        .rst               (rst),
        .clk_override      (clk_override),
        .ch_req_valid      (valid),
        .ch_req_we         (we),
        .ch_req_addr       (addr),
        .ch_req_wdata      (wdata),
        .ch_req_ready      (ready),
        .ch_rsp_valid      (rsp_valid),
        .ch_rsp_data       (rsp_data),
        .bank_conflict_cnt (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic dccm_req_t rq(input logic w, input logic [13:0] a, input logic [38:0] d);
        dccm_req_t r;
        r.we = w;
        r.addr = a;
        r.wdata = d;
        return r;
    endfunction

    // Drive one cycle of requests, check ready, queue expected read data.
    task automatic step(input logic [1:0] v, input dccm_req_t r0, input dccm_req_t r1,
                        input logic [1:0] exp_rdy, input logic [1:0] xv,
                        input logic [38:0] x0, input logic [38:0] x1, input string nm);
        valid = v;
        we    = {r1.we, r0.we};
        addr  = {r1.addr, r0.addr};
        wdata = {r1.wdata, r0.wdata};
        @(negedge clk);
        chk({nm, "_ready"}, 64'(ready), 64'(exp_rdy));
        if (xv[0]) exp_q0.push_back(x0);
        if (xv[1]) exp_q1.push_back(x1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(2'b00, NO, NO, 2'b00, 2'b00, '0, '0, "idle");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every response must match the oldest expectation for that channel.
    always @(negedge clk) begin
        if (rsp_valid[0]) begin
            if (exp_q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp0_unexpected: got data %0h expected no response", rsp_data[38:0]);
            end else begin
                e0 = exp_q0.pop_front();
                chk("rsp0_data", 64'(rsp_data[38:0]), 64'(e0));
            end
        end
        if (rsp_valid[1]) begin
            if (exp_q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp1_unexpected: got data %0h expected no response", rsp_data[77:39]);
            end else begin
                e1 = exp_q1.pop_front();
                chk("rsp1_data", 64'(rsp_data[77:39]), 64'(e1));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with requests pending while reset is held
        valid = 2'b11;
        addr  = {14'h005, 14'h001};
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_cnt", 64'(cnt), 64'h0);
        chk("rst_rsp_data", 64'(rsp_data[38:0]), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid = '0;

        // 1: single channel write then read
        step(2'b01, rq(1'b1, 14'h004, 39'h55), NO, 2'b01, 2'b00, '0, '0, "t1_wr");
        step(2'b01, rq(1'b0, 14'h004, '0), NO, 2'b01, 2'b01, 39'h55, '0, "t1_rd");
        idle();

        // Preload words used by later reads
        step(2'b11, rq(1'b1, 14'h001, 39'h111), rq(1'b1, 14'h002, 39'h222), 2'b11, 2'b00, '0, '0, "pre_a");
        step(2'b10, NO, rq(1'b1, 14'h005, 39'h555), 2'b10, 2'b00, '0, '0, "pre_b");

        // 2: parallel reads in different banks
        step(2'b11, rq(1'b0, 14'h001, '0), rq(1'b0, 14'h002, '0), 2'b11, 2'b11, 39'h111, 39'h222, "t2");
        idle();
        chk("t2_cnt", 64'(cnt), 64'h0);

        // 3: both channels hammer bank 1 straight from reset
        pulse_reset();
        chk("t3_cnt0", 64'(cnt), 64'h0);
        step(2'b11, rq(1'b0, 14'h001, '0), rq(1'b0, 14'h005, '0), 2'b01, 2'b01, 39'h111, '0, "t3_c0");
        step(2'b11, rq(1'b0, 14'h001, '0), rq(1'b0, 14'h005, '0), 2'b10, 2'b10, '0, 39'h555, "t3_c1");
        step(2'b11, rq(1'b0, 14'h001, '0), rq(1'b0, 14'h005, '0), 2'b01, 2'b01, 39'h111, '0, "t3_c2");
        step(2'b11, rq(1'b0, 14'h001, '0), rq(1'b0, 14'h005, '0), 2'b10, 2'b10, '0, 39'h555, "t3_c3");
        idle();
        chk("t3_cnt", 64'(cnt), 64'd4);

        // 4: write on ch0 then read of the same word on ch1 next cycle
        step(2'b01, rq(1'b1, 14'h010, 39'h1AB), NO, 2'b01, 2'b00, '0, '0, "t4_wr");
        step(2'b10, NO, rq(1'b0, 14'h010, '0), 2'b10, 2'b10, '0, 39'h1AB, "t4_rd");
        idle();
        chk("t4_hold_valid", 64'(rsp_valid), 64'h0);
        chk("t4_hold_data", 64'(rsp_data[77:39]), 64'h1AB);

        // Back-to-back reads on one channel with clocks forced on
        clk_override = 1'b1;
        step(2'b01, rq(1'b0, 14'h004, '0), NO, 2'b01, 2'b01, 39'h55, '0, "b2b_0");
        step(2'b01, rq(1'b0, 14'h004, '0), NO, 2'b01, 2'b01, 39'h55, '0, "b2b_1");
        idle();
        clk_override = 1'b0;
        chk("b2b_cnt", 64'(cnt), 64'd4);

        // 5: reset lands the cycle after a read grant
        step(2'b01, rq(1'b0, 14'h004, '0), NO, 2'b01, 2'b00, '0, '0, "t5_rd");
        rst = 1'b1;
        valid = '0;
        @(negedge clk);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_cnt", 64'(cnt), 64'h0);
        step(2'b11, rq(1'b0, 14'h004, '0), rq(1'b0, 14'h010, '0), 2'b01, 2'b01, 39'h55, '0, "t5_rr0");
        step(2'b11, rq(1'b0, 14'h004, '0), rq(1'b0, 14'h010, '0), 2'b10, 2'b10, '0, 39'h1AB, "t5_rr1");
        idle();
        chk("t5_cnt2", 64'(cnt), 64'd2);

        // 6: saturation with continuous conflicting writes to bank 1
        pulse_reset();
        valid = 2'b11;
        we    = 2'b11;
        addr  = {14'h005, 14'h001};
        wdata = {39'h555, 39'h111};
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("t6_pre_sat", 64'(cnt), 64'hFFFE);
        @(posedge clk);
        @(negedge clk);
        chk("t6_sat", 64'(cnt), 64'hFFFF);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t6_no_wrap", 64'(cnt), 64'hFFFF);
        valid = '0;
        we    = '0;
        @(posedge clk);
        #1;
        idle();

        chk("q0_drained", 64'(exp_q0.size()), 64'h0);
        chk("q1_drained", 64'(exp_q1.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
